mux_pipe_nto1: RTL and testbench

Parametrised, registered N-to-1 word selector with valid tracking, stall and flush. It replaces chains of 2:1 selectors in the multicycle datapath, such as the ALU operand, PC-source and write-back selects. Each select is captured in a configurable-latency pipeline so the mux boundary can become a timing cut. Out-of-range selects are detected and flagged, never silently aliased.

---
 rtl/mux_pipe_nto1_if.sv | 30 +++
 rtl/mux_pipe_nto1.sv | 104 ++++++++++
 tb/tb_mux_pipe_nto1.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/mux_pipe_nto1_if.sv
// ---------------------------------------------------------------------------
// mux_pipe_nto1_if
// Bundles the selector's data/control inputs and its registered outputs.
//   master : drives in_data, sel, in_valid, en, flush; observes outputs
//   slave  : the selector itself (consumes inputs, drives outputs)
// ---------------------------------------------------------------------------
interface mux_pipe_nto1_if #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
);
    logic [NUM_IN*WIDTH-1:0] in_data;   // channel k = in_data[k*WIDTH +: WIDTH]
    logic [SEL_W-1:0]        sel;
    logic                    in_valid;
    logic                    en;        // 0 = whole pipeline stalls
    logic                    flush;     // clears every valid/err bit
    logic [WIDTH-1:0]        out_data;
    logic                    out_valid;
    logic                    sel_err;   // output beat had sel >= NUM_IN

    modport master (
        output in_data, sel, in_valid, en, flush,
        input  out_data, out_valid, sel_err
    );

    modport slave (
        input  in_data, sel, in_valid, en, flush,
        output out_data, out_valid, sel_err
    );
endinterface

// File: rtl/mux_pipe_nto1.sv
// ---------------------------------------------------------------------------
// mux_pipe_nto1
// Registered N-to-1 word selector with valid tracking, stall and flush.
// A combinational pick feeds LATENCY register stages of {data, valid, err}.
// Ports:
//   Clk   : clock, rising edge
//   Reset : asynchronous active-high clear of every stage
//   bus   : mux_pipe_nto1_if.slave (in_data, sel, in_valid, en, flush ->
//           out_data, out_valid, sel_err)
// ---------------------------------------------------------------------------
module mux_pipe_nto1 #(
    parameter int WIDTH           = 32,
    parameter int NUM_IN          = 4,
    parameter int SEL_W           = 2,
    parameter int LATENCY         = 1,
    parameter int HOLD_ON_INVALID = 1
) (
    input  logic            Clk,
    input  logic            Reset,
    mux_pipe_nto1_if.slave  bus
);

    // Elaboration-time sanity checks
    if ((2 ** SEL_W) < NUM_IN) begin : g_bad_sel_w
        $error("mux_pipe_nto1: SEL_W too narrow for NUM_IN");
    end
    if (LATENCY < 1 || LATENCY > 3) begin : g_bad_latency
        $error("mux_pipe_nto1: LATENCY must be 1..3");
    end
    if (NUM_IN < 2) begin : g_bad_num_in
        $error("mux_pipe_nto1: NUM_IN must be >= 2");
    end

    localparam logic [SEL_W:0] NUM_IN_C = (SEL_W+1)'(NUM_IN);

    // Stage 0: combinational pick. Unused select codes yield all-zero data
    // rather than aliasing onto a real channel.
    logic [WIDTH-1:0] pick_word;
    logic             pick_err;

    always_comb begin
        pick_word = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (bus.sel == SEL_W'(k)) pick_word = bus.in_data[k*WIDTH +: WIDTH];
        end
        pick_err = bus.in_valid && ({1'b0, bus.sel} >= NUM_IN_C);
    end

    // Register stages: index 0 is fed by the pick, index i by stage i-1.
    logic [LATENCY-1:0]            vld_q, vld_d, err_q, err_d;
    logic [LATENCY-1:0][WIDTH-1:0] data_q, data_d;
    logic [LATENCY-1:0]            src_vld, src_err;
    logic [LATENCY-1:0][WIDTH-1:0] src_data;

    always_comb begin
        src_vld[0]  = bus.in_valid;
        src_err[0]  = pick_err;
        src_data[0] = pick_word;
        for (int i = 1; i < LATENCY; i++) begin
            src_vld[i]  = vld_q[i-1];
            src_err[i]  = err_q[i-1];
            src_data[i] = data_q[i-1];
        end
    end

    always_comb begin
        vld_d  = vld_q;
        err_d  = err_q;
        data_d = data_q;
        if (bus.en) begin
            vld_d = src_vld;
            err_d = src_err;
            for (int i = 0; i < LATENCY; i++) begin
                // In hold mode a stage only takes data behind a valid beat,
                // so the output keeps the last valid word through bubbles.
                if (HOLD_ON_INVALID == 0 || src_vld[i]) data_d[i] = src_data[i];
            end
        end
        // Flush beats stall: valid/err always clear, and in hold mode the
        // data registers are left untouched as well.
        if (bus.flush) begin
            vld_d = '0;
            err_d = '0;
            if (HOLD_ON_INVALID != 0) data_d = data_q;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            vld_q  <= '0;
            err_q  <= '0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            err_q  <= err_d;
            data_q <= data_d;
        end
    end

    assign bus.out_data  = data_q[LATENCY-1];
    assign bus.out_valid = vld_q[LATENCY-1];
    assign bus.sel_err   = err_q[LATENCY-1];

endmodule

// File: tb/tb_mux_pipe_nto1.sv
// ---------------------------------------------------------------------------
// tb_mux_pipe_nto1
// Four selector instances share one stimulus stream:
//   u0 NUM_IN=4 LATENCY=1 HOLD=1   u1 NUM_IN=3 LATENCY=2 HOLD=0
//   u2 NUM_IN=4 LATENCY=3 HOLD=1   u3 NUM_IN=4 LATENCY=1 HOLD=0
// A per-instance model tracks the beat accepted on each enabled edge by age;
// the output is the entry LATENCY-1 ages old. Directed literal checks pin
// the model to hand-computed values.
// ---------------------------------------------------------------------------
module tb_mux_pipe_nto1;

    localparam int LATS [4] = '{1, 2, 3, 1};
    localparam int HOLDS[4] = '{1, 0, 1, 0};
    localparam int NINS [4] = '{4, 3, 4, 4};

    logic        Clk = 1'b0;
    logic        Reset;
    logic [127:0] in_data;
    logic [1:0]  sel;
    logic        in_valid, en, flush;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 Clk = ~Clk;

    mux_pipe_nto1_if #(.WIDTH(32), .NUM_IN(4), .SEL_W(2)) if0 ();
    mux_pipe_nto1_if #(.WIDTH(32), .NUM_IN(3), .SEL_W(2)) if1 ();
    mux_pipe_nto1_if #(.WIDTH(32), .NUM_IN(4), .SEL_W(2)) if2 ();
    mux_pipe_nto1_if #(.WIDTH(32), .NUM_IN(4), .SEL_W(2)) if3 ();

    assign if0.in_data = in_data;        assign if1.in_data = in_data[95:0];
    assign if2.in_data = in_data;        assign if3.in_data = in_data;
    assign if0.sel = sel;  assign if1.sel = sel;  assign if2.sel = sel;  assign if3.sel = sel;
    assign if0.in_valid = in_valid;  assign if1.in_valid = in_valid;
    assign if2.in_valid = in_valid;  assign if3.in_valid = in_valid;
    assign if0.en = en;  assign if1.en = en;  assign if2.en = en;  assign if3.en = en;
    assign if0.flush = flush;  assign if1.flush = flush;
    assign if2.flush = flush;  assign if3.flush = flush;

    mux_pipe_nto1 #(.WIDTH(32), .NUM_IN(4), .SEL_W(2), .LATENCY(1), .HOLD_ON_INVALID(1))
        u0 (.Clk(Clk), .Reset(Reset), .bus(if0));
    mux_pipe_nto1 #(.WIDTH(32), .NUM_IN(3), .SEL_W(2), .LATENCY(2), .HOLD_ON_INVALID(0))
        u1 (.Clk(Clk), .Reset(Reset), .bus(if1));
    mux_pipe_nto1 #(.WIDTH(32), .NUM_IN(4), .SEL_W(2), .LATENCY(3), .HOLD_ON_INVALID(1))
        u2 (.Clk(Clk), .Reset(Reset), .bus(if2));
    mux_pipe_nto1 #(.WIDTH(32), .NUM_IN(4), .SEL_W(2), .LATENCY(1), .HOLD_ON_INVALID(0))
        u3 (.Clk(Clk), .Reset(Reset), .bus(if3));

    logic [31:0] o_d[4];
    logic        o_v[4], o_e[4];
    assign o_d[0] = if0.out_data;  assign o_v[0] = if0.out_valid;  assign o_e[0] = if0.sel_err;
    assign o_d[1] = if1.out_data;  assign o_v[1] = if1.out_valid;  assign o_e[1] = if1.sel_err;
    assign o_d[2] = if2.out_data;  assign o_v[2] = if2.out_valid;  assign o_e[2] = if2.sel_err;
    assign o_d[3] = if3.out_data;  assign o_v[3] = if3.out_valid;  assign o_e[3] = if3.sel_err;

    // ---------------- model: accepted beats by age (0 = newest) ------------
    bit          m_v[4][3];
    bit          m_e[4][3];
    logic [31:0] m_w[4][3];
    logic [31:0] m_hold[4];   // last word that left the pipe as a valid beat

    task automatic model_reset();
        for (int d = 0; d < 4; d++) begin
            for (int a = 0; a < 3; a++) begin
                m_v[d][a] = 1'b0; m_e[d][a] = 1'b0; m_w[d][a] = '0;
            end
            m_hold[d] = '0;
        end
    endtask

    task automatic model_edge();
        for (int d = 0; d < 4; d++) begin
            bit          pe;
            logic [31:0] pw;
            if (flush) begin
                for (int a = 0; a < 3; a++) begin m_v[d][a] = 1'b0; m_e[d][a] = 1'b0; end
            end
            if (en) begin
                for (int a = 2; a > 0; a--) begin
                    m_v[d][a] = m_v[d][a-1]; m_e[d][a] = m_e[d][a-1]; m_w[d][a] = m_w[d][a-1];
                end
                pe = (int'(sel) >= NINS[d]);
                pw = pe ? 32'h0 : in_data[int'(sel)*32 +: 32];
                m_v[d][0] = in_valid && !flush;
                m_e[d][0] = in_valid && !flush && pe;
                m_w[d][0] = pw;
                if (!flush && m_v[d][LATS[d]-1]) m_hold[d] = m_w[d][LATS[d]-1];
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare against the model ------------------
    always @(negedge Clk) begin
        for (int d = 0; d < 4; d++) begin
            int          lo;
            logic [31:0] ew;
            lo = LATS[d] - 1;
            ew = (HOLDS[d] != 0) ? m_hold[d] : m_w[d][lo];
            check($sformatf("u%0d out_valid", d), 32'(o_v[d]), 32'(m_v[d][lo]));
            check($sformatf("u%0d sel_err", d),   32'(o_e[d]), 32'(m_e[d][lo]));
            if (HOLDS[d] != 0 || m_v[d][lo])
                check($sformatf("u%0d out_data", d), o_d[d], ew);
        end
    end

    // ---------------- stimulus ---------------------------------------------
    task automatic set_ch(input logic [31:0] c0, c1, c2, c3);
        in_data = {c3, c2, c1, c0};
    endtask

    // Apply one cycle of inputs; returns 1 time unit after the falling edge.
    task automatic step(input bit v, input int s, input bit e, input bit f);
        in_valid = v; sel = s[1:0]; en = e; flush = f;
        @(posedge Clk);
        if (!Reset) model_edge();
        @(negedge Clk);
        #1;
    endtask

    initial begin
        Reset = 1'b1;
        in_valid = 1'b0; sel = '0; en = 1'b1; flush = 1'b0;
        set_ch(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
        model_reset();
        @(negedge Clk); @(negedge Clk); #1;
        check("reset u0 out_valid", 32'(if0.out_valid), 32'h0);
        check("reset u0 out_data",  if0.out_data, 32'h0);
        Reset = 1'b0;

        // Select sweep, back to back
        for (int k = 0; k < 4; k++) begin
            step(1, k, 1, 0);
            check($sformatf("sweep u0 data sel%0d", k), if0.out_data, 32'h11111111 * (k + 1));
            check($sformatf("sweep u0 valid sel%0d", k), 32'(if0.out_valid), 32'h1);
        end
        check("sweep u0 sel3 no err", 32'(if0.sel_err), 32'h0);
        check("u1 lat2 data", if1.out_data, 32'h33333333);

        // u1 (NUM_IN=3) sees the sel=3 beat now
        step(1, 1, 1, 0);
        check("oor u1 valid", 32'(if1.out_valid), 32'h1);
        check("oor u1 err",   32'(if1.sel_err),   32'h1);
        check("oor u1 data",  if1.out_data,       32'h0);

        // Hold-mode contrast on a bubble
        set_ch(32'h12345678, 32'h22222222, 32'h33333333, 32'h44444444);
        step(0, 0, 1, 0);
        check("oor next u1 err",  32'(if1.sel_err), 32'h0);
        check("oor next u1 data", if1.out_data,     32'h22222222);
        check("hold1 u0 valid",   32'(if0.out_valid), 32'h0);
        check("hold1 u0 data",    if0.out_data,     32'h22222222);
        check("hold0 u3 valid",   32'(if3.out_valid), 32'h0);
        check("hold0 u3 data",    if3.out_data,     32'h12345678);

        // Stall on u1 (LATENCY=2): A enters, 3 stalled edges, then B
        set_ch(32'hA5A5A5A5, 32'h5A5A5A5A, 32'h33333333, 32'h44444444);
        step(1, 0, 1, 0);
        for (int k = 0; k < 3; k++) step(1, 1, 0, 0);
        check("stall u1 no early A", 32'(if1.out_valid), 32'h0);
        step(1, 1, 1, 0);
        check("stall u1 A valid", 32'(if1.out_valid), 32'h1);
        check("stall u1 A data",  if1.out_data,       32'hA5A5A5A5);
        step(0, 0, 1, 0);
        check("stall u1 B valid", 32'(if1.out_valid), 32'h1);
        check("stall u1 B data",  if1.out_data,       32'h5A5A5A5A);
        step(0, 0, 1, 0);
        check("stall u1 no dup",  32'(if1.out_valid), 32'h0);

        // Flush priority on u2 (LATENCY=3, hold mode)
        set_ch(32'hDEADBEEF, 32'hCAFEF00D, 32'h0BADF00D, 32'h44444444);
        step(1, 0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        check("flush u2 pre valid", 32'(if2.out_valid), 32'h1);
        check("flush u2 pre data",  if2.out_data,       32'hDEADBEEF);
        step(1, 1, 1, 0);
        step(1, 2, 1, 0);
        step(1, 3, 0, 1);   // flush with en=0 and a fresh beat
        for (int k = 0; k < 3; k++) begin
            check($sformatf("flush u2 valid c%0d", k), 32'(if2.out_valid), 32'h0);
            check($sformatf("flush u2 data c%0d", k),  if2.out_data,       32'hDEADBEEF);
            step(0, 0, 1, 0);
        end

        // Asynchronous reset with three beats in flight on u2
        step(1, 0, 1, 0);
        step(1, 1, 1, 0);
        step(1, 2, 1, 0);
        check("inflight u2 valid", 32'(if2.out_valid), 32'h1);
        Reset = 1'b1;
        model_reset();
        #1;
        check("async rst u2 valid", 32'(if2.out_valid), 32'h0);
        check("async rst u2 err",   32'(if2.sel_err),   32'h0);
        check("async rst u2 data",  if2.out_data,       32'h0);
        @(negedge Clk); #1;
        Reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step(0, 0, 1, 0);
            check($sformatf("post rst u2 valid c%0d", k), 32'(if2.out_valid), 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
